// File: rtl/unary_stream_collector.sv
// Deserialises a y/valid unary bit stream into an LSB-first word plus its ones count,
// handed off over valid/ready. Optional thermometer-code check: UNARY_COLLECT_THERM_CHECK_EN.
module unary_stream_collector #(
    parameter int unsigned INPUT_WIDTH = 16,
    parameter int unsigned COUNT_WIDTH = $clog2(INPUT_WIDTH + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic                   stream_bit_i,
    input  logic                   stream_valid_i,
    output logic [INPUT_WIDTH-1:0] word_out_o,
    output logic [COUNT_WIDTH-1:0] ones_count_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
`ifdef UNARY_COLLECT_THERM_CHECK_EN
    output logic                   therm_err_o,
`endif
    output logic                   busy_o
);

    localparam int unsigned IdxW = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(INPUT_WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

    state_e                 state_q, state_d;
    logic [INPUT_WIDTH-1:0] word_q, word_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic                   clear;

`ifdef UNARY_COLLECT_THERM_CHECK_EN
    logic seen_zero_q, seen_zero_d;
    logic therm_err_q, therm_err_d;
`endif

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        count_d = count_q;
        idx_d   = idx_q;
        clear   = 1'b0;
`ifdef UNARY_COLLECT_THERM_CHECK_EN
        seen_zero_d = seen_zero_q;
        therm_err_d = therm_err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StCollect;
                    clear   = 1'b1;
                end
            end
            StCollect: begin
                // A start in the same cycle as a stream bit discards the bit.
                if (start_i) begin
                    clear = 1'b1;
                end else if (stream_valid_i) begin
                    word_d[idx_q] = stream_bit_i;
                    count_d       = count_q + COUNT_WIDTH'(stream_bit_i);
                    idx_d         = idx_q + 1'b1;
`ifdef UNARY_COLLECT_THERM_CHECK_EN
                    if (stream_bit_i && seen_zero_q) therm_err_d = 1'b1;
                    if (!stream_bit_i) seen_zero_d = 1'b1;
`endif
                    if (idx_q == LastIdx) state_d = StDone;
                end
            end
            StDone: begin
                // Start is only honoured together with the handoff, so a result is never lost.
                if (out_ready_i) begin
                    if (start_i) begin
                        state_d = StCollect;
                        clear   = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (clear) begin
            word_d  = '0;
            count_d = '0;
            idx_d   = '0;
`ifdef UNARY_COLLECT_THERM_CHECK_EN
            seen_zero_d = 1'b0;
            therm_err_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            word_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            count_q <= count_d;
            idx_q   <= idx_d;
        end
    end

`ifdef UNARY_COLLECT_THERM_CHECK_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seen_zero_q <= 1'b0;
            therm_err_q <= 1'b0;
        end else begin
            seen_zero_q <= seen_zero_d;
            therm_err_q <= therm_err_d;
        end
    end

    assign therm_err_o = therm_err_q;
`endif

    assign word_out_o   = word_q;
    assign ones_count_o = count_q;
    assign out_valid_o  = (state_q == StDone);
    assign busy_o       = (state_q == StCollect);

endmodule

// File: tb/tb_unary_stream_collector.sv
// Scoreboard bench for unary_stream_collector: driver pushes expected words, monitor pops on out_valid.
module tb_unary_stream_collector;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] w;
        int           cnt;
        logic         th;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stream_bit, stream_valid, out_ready;
    logic [W-1:0] word_out;
    logic [4:0]  ones_count;
    logic        out_valid, busy;
`ifdef UNARY_COLLECT_THERM_CHECK_EN
    logic        therm_err;
`endif

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   armed = 1'b0;
    exp_t last_exp;

    always #5 clk = ~clk;

    unary_stream_collector dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .stream_bit_i   (stream_bit),
        .stream_valid_i (stream_valid),
        .word_out_o     (word_out),
        .ones_count_o   (ones_count),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
`ifdef UNARY_COLLECT_THERM_CHECK_EN
        .therm_err_o    (therm_err),
`endif
        .busy_o         (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: unary value is the popcount; thermometer iff w is 2^k-1.
    function automatic exp_t model(input logic [W-1:0] w);
        exp_t e;
        e.w   = w;
        e.cnt = 0;
        for (int i = 0; i < W; i++) e.cnt += int'(w[i]);
        e.th  = (((w + 1'b1) & w) != '0);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_word_clr", 32'(word_out), 32'd0);
        check("start_cnt_clr", 32'(ones_count), 32'd0);
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int first, input int last,
                             input logic [W-1:0] gap_mask, input int gap_len, input int max_gap);
        for (int i = first; i <= last; i++) begin
            repeat ($urandom_range(max_gap, 0)) begin
                stream_valid = 1'b0;
                stream_bit   = 1'($urandom);
                tick();
            end
            stream_bit   = w[i];
            stream_valid = 1'b1;
            if (i == W - 1) begin
                last_exp = model(w);
                exp_q.push_back(last_exp);
                check("pre_last_valid", 32'(out_valid), 32'd0);
            end
            tick();
            stream_valid = 1'b0;
            if (i == W - 1) begin
                check("latency_valid", 32'(out_valid), 32'd1);
                check("done_busy", 32'(busy), 32'd0);
            end
            if (gap_mask[i]) begin
                repeat (gap_len) begin
                    stream_bit = 1'($urandom);
                    tick();
                end
            end
        end
    endtask

    task automatic collect(input logic [W-1:0] w, input logic [W-1:0] gap_mask,
                           input int gap_len, input int max_gap);
        if (!armed) start_pulse();
        armed = 1'b0;
        send_bits(w, 0, W - 1, gap_mask, gap_len, max_gap);
    endtask

    task automatic handoff(input int hold, input bit stray, input bit start_with_ready);
        out_ready = 1'b0;
        repeat (hold) begin
            if (stray) begin
                stream_valid = 1'($urandom);
                stream_bit   = 1'($urandom);
                start        = 1'($urandom);
            end
            tick();
        end
        stream_valid = 1'b0;
        check("held_valid", 32'(out_valid), 32'd1);
        start     = start_with_ready;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check("handoff_drop", 32'(out_valid), 32'd0);
        check("handoff_busy", 32'(busy), 32'(start_with_ready));
        if (start_with_ready) begin
            check("restart_word", 32'(word_out), 32'd0);
            check("restart_cnt", 32'(ones_count), 32'd0);
        end else begin
            check("retain_word", 32'(word_out), 32'(last_exp.w));
            check("retain_cnt", 32'(ones_count), 32'(last_exp.cnt));
        end
        armed = start_with_ready;
    endtask

    // Monitor: pop on each new result, then require it stays stable while presented.
    exp_t cur;
    bit   prev_valid = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    check("word_out", 32'(word_out), 32'(cur.w));
                    check("ones_count", 32'(ones_count), 32'(cur.cnt));
`ifdef UNARY_COLLECT_THERM_CHECK_EN
                    check("therm_err", 32'(therm_err), 32'(cur.th));
`endif
                end
            end else if (out_valid && prev_valid) begin
                check("stable_word", 32'(word_out), 32'(cur.w));
                check("stable_cnt", 32'(ones_count), 32'(cur.cnt));
            end
            prev_valid <= out_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; stream_bit = 1'b0; stream_valid = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        check("rst_word", 32'(word_out), 32'd0);
        check("rst_cnt", 32'(ones_count), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // Stream bits in IDLE must be ignored.
        stream_valid = 1'b1; stream_bit = 1'b1;
        repeat (3) tick();
        stream_valid = 1'b0;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_cnt", 32'(ones_count), 32'd0);

        collect(16'hFFFF, '0, 0, 0);
        handoff(0, 1'b0, 1'b0);

        collect(16'h00FF, 16'h0810, 3, 0);
        handoff(1, 1'b0, 1'b0);

        collect(16'h0A05, '0, 0, 1);
        handoff(5, 1'b1, 1'b0);

        // Restart mid-collection: first 7 bits are discarded.
        start_pulse();
        send_bits(16'h7F3C, 0, 6, '0, 0, 0);
        collect(16'h0003, '0, 0, 1);
        handoff(2, 1'b0, 1'b0);

        // Reset after 9 bits.
        start_pulse();
        send_bits(16'hFFFF, 0, 8, '0, 0, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_word", 32'(word_out), 32'd0);
        check("midrst_cnt", 32'(ones_count), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        collect(16'h1234, '0, 0, 2);
        handoff(0, 1'b0, 1'b0);

        collect(16'h0005, '0, 0, 0);
        handoff(0, 1'b0, 1'b1);
        collect(16'h0007, '0, 0, 0);
        handoff(1, 1'b1, 1'b0);

        for (int n = 0; n < 24; n++) begin
            logic [W-1:0] w;
            w = W'($urandom);
            if ($urandom_range(2, 0) == 0) w = W'((32'd1 << $urandom_range(W, 0)) - 1);
            collect(w, W'($urandom), $urandom_range(2, 0), $urandom_range(2, 0));
            handoff($urandom_range(4, 0), 1'($urandom), (n != 23) && 1'($urandom));
        end

        repeat (4) tick();
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
